// File: rtl/axi_pkg.sv
// Shared constants for the AXI read-channel arbiter: system dimensions,
// the fixed slave address map, and the per-master FSM state encoding.
// Optional feature macro (used by read_arbiter): AXI_DEFAULT_SLAVE_EN.
package axi_pkg;

    localparam int NUM_M     = 3;
    localparam int NUM_S     = 6;
    localparam int MIDX_BITS = 2;
    localparam int SIDX_BITS = 3;

    // Address map; element i describes slave i (inclusive bounds).
    localparam logic [NUM_S-1:0][31:0] S_BEGIN = {
        32'h2000_0000,  // S5
        32'h1001_0000,  // S4
        32'h1002_0000,  // S3
        32'h0002_0000,  // S2
        32'h0001_0000,  // S1
        32'h0000_0000   // S0
    };

    localparam logic [NUM_S-1:0][31:0] S_END = {
        32'h201F_FFFF,  // S5
        32'h1001_03FF,  // S4
        32'h1002_03FF,  // S3
        32'h0002_FFFF,  // S2
        32'h0001_FFFF,  // S1
        32'h0000_3FFF   // S0
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } mst_state_t;

    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/addr_decoder.sv
// Address decoder: maps a read address onto the fixed slave map.
// A miss reports hit=0 and index NUM_S (the default-slave slot), so the
// caller decides whether a miss is routable.
module addr_decoder
    import axi_pkg::*;
(
    input  logic [31:0]          i_addr,
    output logic [SIDX_BITS-1:0] o_idx,
    output logic                 o_hit
);

    // Regions do not overlap, so at most one comparison can match.
    always_comb begin
        o_idx = SIDX_BITS'(NUM_S);
        o_hit = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (addr_in_range(i_addr, S_BEGIN[i], S_END[i])) begin
                o_idx = SIDX_BITS'(i);
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_arbiter.sv
// AXI read-address arbiter: one IDLE/ADDR/DATA FSM per master and a
// busy/owner/round-robin-pointer triple per slave slot (slot NUM_S is the
// default slave). Index outputs come straight from registers.
// Optional feature: define AXI_DEFAULT_SLAVE_EN to route unmapped reads to
// the default slave; otherwise unmapped requests stay in IDLE.
module read_arbiter #(
    parameter int NUM_M     = axi_pkg::NUM_M,
    parameter int NUM_S     = axi_pkg::NUM_S,
    parameter int MIDX_BITS = axi_pkg::MIDX_BITS,
    parameter int SIDX_BITS = axi_pkg::SIDX_BITS
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_M-1:0]                  ARVALID_M,
    input  logic [NUM_M-1:0][31:0]            ARADDR_M,
    input  logic [NUM_M-1:0]                  ARREADY_M,
    input  logic [NUM_M-1:0]                  RVALID_M,
    input  logic [NUM_M-1:0]                  RREADY_M,
    input  logic [NUM_M-1:0]                  RLAST_M,
    output logic [NUM_S:0][MIDX_BITS-1:0]     SRIdx,
    output logic [NUM_M-1:0][SIDX_BITS-1:0]   MRIdx
);

    import axi_pkg::mst_state_t;
    import axi_pkg::ST_IDLE;
    import axi_pkg::ST_ADDR;
    import axi_pkg::ST_DATA;

    localparam int NSLOT = NUM_S + 1;
    localparam logic [MIDX_BITS-1:0] DUMMY_M = MIDX_BITS'(NUM_M);
    localparam logic [SIDX_BITS-1:0] DUMMY_S = SIDX_BITS'(NUM_S + 1);

    // Per-master state; r_sidx doubles as the MRIdx output register.
    mst_state_t           r_state [NUM_M];
    logic [SIDX_BITS-1:0] r_sidx  [NUM_M];

    // Per-slave state; r_owner doubles as the SRIdx output register.
    logic [NSLOT-1:0]     r_busy;
    logic [MIDX_BITS-1:0] r_owner [NSLOT];
    logic [MIDX_BITS-1:0] r_ptr   [NSLOT];

    logic [SIDX_BITS-1:0] w_target [NUM_M];
    logic [NUM_M-1:0]     w_dec_hit;
    logic [NUM_M-1:0]     w_routable;
    logic [NUM_M-1:0]     w_eligible;
    logic [NUM_M-1:0]     w_m_done;
    logic [NUM_M-1:0]     w_m_gnt;
    logic [NSLOT-1:0]     w_gnt_vld;
    logic [MIDX_BITS-1:0] w_gnt_idx [NSLOT];
    logic [NSLOT-1:0]     w_release;

    genvar gi;

    // ---------------- per-master decode and request qualification --------
    generate
        for (gi = 0; gi < NUM_M; gi++) begin : g_mst
            addr_decoder u_dec (
                .i_addr (ARADDR_M[gi]),
                .o_idx  (w_target[gi]),
                .o_hit  (w_dec_hit[gi])
            );

`ifdef AXI_DEFAULT_SLAVE_EN
            // A miss already decodes to the default-slave slot.
            assign w_routable[gi] = w_dec_hit[gi] | (w_target[gi] == SIDX_BITS'(NUM_S));
`else
            assign w_routable[gi] = w_dec_hit[gi];
`endif

            // Address is only looked at while IDLE, so later changes are ignored.
            assign w_eligible[gi] = (r_state[gi] == ST_IDLE) & ARVALID_M[gi] & w_routable[gi];
            assign w_m_done[gi]   = (r_state[gi] == ST_DATA) & RVALID_M[gi] & RREADY_M[gi] & RLAST_M[gi];
            assign w_m_gnt[gi]    = w_eligible[gi] & w_gnt_vld[w_target[gi]] &
                                    (w_gnt_idx[w_target[gi]] == MIDX_BITS'(gi));
            assign MRIdx[gi]      = r_sidx[gi];
        end
    endgenerate

    // ---------------- per-slave request collection and round-robin -------
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slv
            logic [NUM_M-1:0]     w_req;
            logic                 w_rel;
            logic                 w_gv;
            logic [MIDX_BITS-1:0] w_gidx;

            // Gather requests for this slot (only while free) and detect release.
            always_comb begin
                w_req = '0;
                w_rel = 1'b0;
                for (int m = 0; m < NUM_M; m++) begin
                    if (w_eligible[m] && (w_target[m] == SIDX_BITS'(gi)) && !r_busy[gi])
                        w_req[m] = 1'b1;
                    if (w_m_done[m] && (r_sidx[m] == SIDX_BITS'(gi)))
                        w_rel = 1'b1;
                end
            end

            // Round-robin pick: first requester at or after the pointer, wrapping.
            always_comb begin
                logic [MIDX_BITS-1:0] cand;
                w_gv   = 1'b0;
                w_gidx = '0;
                cand   = '0;
                for (int k = 0; k < NUM_M; k++) begin
                    cand = MIDX_BITS'((int'(r_ptr[gi]) + k) % NUM_M);
                    if (!w_gv && w_req[cand]) begin
                        w_gv   = 1'b1;
                        w_gidx = cand;
                    end
                end
            end

            assign w_gnt_vld[gi] = w_gv;
            assign w_gnt_idx[gi] = w_gidx;
            assign w_release[gi] = w_rel;
            assign SRIdx[gi]     = r_owner[gi];
        end
    endgenerate

    // Master FSMs and slave bookkeeping; reset aborts every grant at once.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int m = 0; m < NUM_M; m++) begin
                r_state[m] <= ST_IDLE;
                r_sidx[m]  <= DUMMY_S;
            end
            r_busy <= '0;
            for (int s = 0; s < NSLOT; s++) begin
                r_owner[s] <= DUMMY_M;
                r_ptr[s]   <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                case (r_state[m])
                    ST_IDLE: begin
                        if (w_m_gnt[m]) begin
                            r_state[m] <= ST_ADDR;
                            r_sidx[m]  <= w_target[m];
                        end
                    end
                    ST_ADDR: begin
                        if (ARVALID_M[m] && ARREADY_M[m])
                            r_state[m] <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (w_m_done[m]) begin
                            r_state[m] <= ST_IDLE;
                            r_sidx[m]  <= DUMMY_S;
                        end
                    end
                    default: begin
                        r_state[m] <= ST_IDLE;
                        r_sidx[m]  <= DUMMY_S;
                    end
                endcase
            end
            // Grant only looks at the registered busy flag, so a slot freed
            // at this edge cannot be handed out again until the next one.
            for (int s = 0; s < NSLOT; s++) begin
                if (w_gnt_vld[s]) begin
                    r_busy[s]  <= 1'b1;
                    r_owner[s] <= w_gnt_idx[s];
                    r_ptr[s]   <= MIDX_BITS'((int'(w_gnt_idx[s]) + 1) % NUM_M);
                end else if (w_release[s]) begin
                    r_busy[s]  <= 1'b0;
                    r_owner[s] <= DUMMY_M;
                end
            end
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// Directed bench for read_arbiter with a scoreboard of expected index values.
// Honors AXI_DEFAULT_SLAVE_EN for the unmapped-address scenario.
`timescale 1ns/1ps
module tb_read_arbiter;

    localparam int DM = 3;  // dummy master index
    localparam int DS = 7;  // dummy slave index
`ifdef AXI_DEFAULT_SLAVE_EN
    localparam bit DFLT_EN = 1'b1;
`else
    localparam bit DFLT_EN = 1'b0;
`endif

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic [2:0]      ARVALID_M, ARREADY_M, RVALID_M, RREADY_M, RLAST_M;
    logic [2:0][31:0] ARADDR_M;
    logic [6:0][1:0] SRIdx;
    logic [2:0][2:0] MRIdx;

    int    n_checks = 0;
    int    n_pass   = 0;
    string scen     = "init";
    int    cyc      = 0;

    typedef struct {
        string tag;
        bit    is_m;
        int    idx;
        int    exp;
    } exp_t;
    exp_t sb_q[$];

    always #5 ACLK = ~ACLK;

    read_arbiter dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ARVALID_M (ARVALID_M),
        .ARADDR_M  (ARADDR_M),
        .ARREADY_M (ARREADY_M),
        .RVALID_M  (RVALID_M),
        .RREADY_M  (RREADY_M),
        .RLAST_M   (RLAST_M),
        .SRIdx     (SRIdx),
        .MRIdx     (MRIdx)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic exp_m(input int m, input int v);
        exp_t e;
        e.tag = $sformatf("MRIdx[%0d]", m); e.is_m = 1'b1; e.idx = m; e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_s(input int s, input int v);
        exp_t e;
        e.tag = $sformatf("SRIdx[%0d]", s); e.is_m = 1'b0; e.idx = s; e.exp = v;
        sb_q.push_back(e);
    endtask

    // Pop every pending expectation and compare it against the live outputs.
    task automatic drain();
        while (sb_q.size() > 0) begin
            exp_t e;
            int   got;
            e   = sb_q.pop_front();
            got = e.is_m ? int'(MRIdx[e.idx]) : int'(SRIdx[e.idx]);
            check_val($sformatf("%s c%0d %s", scen, cyc, e.tag), got, e.exp);
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        @(negedge ACLK);
        drain();
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic clr_inputs();
        ARVALID_M = '0; ARREADY_M = '0; RVALID_M = '0; RREADY_M = '0; RLAST_M = '0;
        ARADDR_M  = '0;
    endtask

    task automatic set_r(input int m, input logic v);
        RVALID_M[m] = v; RREADY_M[m] = v; RLAST_M[m] = v;
    endtask

    task automatic do_reset(input string name);
        ARESETn = 1'b0;
        clr_inputs();
        repeat (2) @(posedge ACLK);
        #1;
        scen = {name, "/rst"};
        for (int m = 0; m < 3; m++) exp_m(m, DS);
        for (int s = 0; s < 7; s++) exp_s(s, DM);
        @(negedge ACLK);
        drain();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        scen = name;
        cyc  = 0;
    endtask

    initial begin
        clr_inputs();

        // ---- single read: ARREADY in cycle 3, RLAST in cycle 6 ----
        do_reset("single");
        ARVALID_M[0] = 1'b1; ARADDR_M[0] = 32'h0001_0040;
        exp_m(0, DS); step();                                   // c0
        exp_m(0, 1); exp_s(1, 0); step();                       // c1
        ARADDR_M[0] = 32'h0000_0000;                            // ignored outside IDLE
        exp_m(0, 1); exp_s(1, 0); exp_s(0, DM); step();         // c2
        ARREADY_M[0] = 1'b1;
        exp_m(0, 1); exp_s(1, 0); step();                       // c3
        ARVALID_M[0] = 1'b0; ARREADY_M[0] = 1'b0;
        exp_m(0, 1); exp_s(1, 0); step();                       // c4
        exp_m(0, 1); exp_s(1, 0); step();                       // c5
        set_r(0, 1'b1);
        exp_m(0, 1); exp_s(1, 0); step();                       // c6
        set_r(0, 1'b0);
        exp_m(0, DS); exp_s(1, DM); step();                     // c7

        // ---- contention: all three masters on S2 ----
        do_reset("contend");
        ARVALID_M = 3'b111;
        for (int m = 0; m < 3; m++) ARADDR_M[m] = 32'h0002_0000;
        exp_m(0, DS); exp_m(1, DS); exp_m(2, DS); step();       // c0
        exp_m(0, 2); exp_m(1, DS); exp_m(2, DS); exp_s(2, 0);
        ARREADY_M[0] = 1'b1; step();                            // c1
        ARVALID_M[0] = 1'b0; ARREADY_M[0] = 1'b0; set_r(0, 1'b1);
        exp_s(2, 0); step();                                    // c2
        set_r(0, 1'b0);
        exp_m(0, DS); exp_m(1, DS); exp_s(2, DM); step();       // c3
        exp_m(1, 2); exp_m(2, DS); exp_s(2, 1);
        ARREADY_M[1] = 1'b1; step();                            // c4
        ARVALID_M[1] = 1'b0; ARREADY_M[1] = 1'b0; set_r(1, 1'b1);
        exp_m(1, 2); step();                                    // c5
        set_r(1, 1'b0);
        exp_m(1, DS); exp_m(2, DS); exp_s(2, DM); step();       // c6
        exp_m(2, 2); exp_s(2, 2);
        ARREADY_M[2] = 1'b1; step();                            // c7
        ARVALID_M[2] = 1'b0; ARREADY_M[2] = 1'b0; set_r(2, 1'b1);
        step();                                                 // c8
        set_r(2, 1'b0);
        exp_m(2, DS); exp_s(2, DM); step();                     // c9

        // ---- parallel: M0->S0 and M1->S5 in the same cycle ----
        do_reset("parallel");
        ARVALID_M[0] = 1'b1; ARADDR_M[0] = 32'h0000_0100;
        ARVALID_M[1] = 1'b1; ARADDR_M[1] = 32'h2000_0000;
        exp_m(0, DS); exp_m(1, DS); step();                     // c0
        exp_m(0, 0); exp_m(1, 5); exp_s(0, 0); exp_s(5, 1);
        ARREADY_M[1:0] = 2'b11; step();                         // c1
        ARVALID_M[1:0] = 2'b00; ARREADY_M[1:0] = 2'b00;
        set_r(0, 1'b1); set_r(1, 1'b1);
        exp_m(0, 0); exp_m(1, 5); step();                       // c2
        set_r(0, 1'b0); set_r(1, 1'b0);
        exp_m(0, DS); exp_m(1, DS); exp_s(0, DM); exp_s(5, DM); step();  // c3

        // ---- unmapped address from M2 ----
        do_reset("unmapped");
        ARVALID_M[2] = 1'b1; ARADDR_M[2] = 32'h3000_0000;
        exp_m(2, DS); step();                                   // c0
        for (int k = 0; k < 3; k++) begin                       // c1..c3
            exp_m(2, DFLT_EN ? 6 : DS); exp_s(6, DFLT_EN ? 2 : DM); step();
        end
        ARREADY_M[2] = 1'b1;
        exp_m(2, DFLT_EN ? 6 : DS); step();                     // c4
        ARVALID_M[2] = 1'b0; ARREADY_M[2] = 1'b0; set_r(2, 1'b1);
        exp_m(2, DFLT_EN ? 6 : DS); step();                     // c5
        set_r(2, 1'b0);
        exp_m(2, DS); exp_s(6, DM); step();                     // c6

        // ---- reset asserted while M1 is in DATA ----
        do_reset("rst_mid");
        ARVALID_M[1] = 1'b1; ARADDR_M[1] = 32'h0000_0200;
        step();                                                 // c0
        exp_m(1, 0); exp_s(0, 1);
        ARREADY_M[1] = 1'b1; step();                            // c1
        ARVALID_M[1] = 1'b0; ARREADY_M[1] = 1'b0;
        exp_m(1, 0); exp_s(0, 1); step();                       // c2 (DATA)
        #2;
        ARESETn = 1'b0;
        #1;
        scen = "rst_mid/async";
        exp_m(1, DS);
        for (int s = 0; s < 7; s++) exp_s(s, DM);
        drain();                                                // no edge yet

        // ---- re-grant after release, then round-robin pointer wrap ----
        do_reset("regrant");
        ARVALID_M[0] = 1'b1; ARADDR_M[0] = 32'h0002_0010;
        step();                                                 // c0
        exp_m(0, 2); exp_s(2, 0);
        ARVALID_M[1] = 1'b1; ARADDR_M[1] = 32'h0002_0020;
        ARREADY_M[0] = 1'b1; step();                            // c1
        ARVALID_M[0] = 1'b0; ARREADY_M[0] = 1'b0; set_r(0, 1'b1);
        exp_m(1, DS); exp_s(2, 0); step();                      // c2 (release edge next)
        set_r(0, 1'b0);
        exp_m(0, DS); exp_m(1, DS); exp_s(2, DM); step();       // c3
        exp_m(1, 2); exp_s(2, 1);
        ARREADY_M[1] = 1'b1; step();                            // c4
        ARVALID_M[1] = 1'b0; ARREADY_M[1] = 1'b0; set_r(1, 1'b1);
        step();                                                 // c5
        set_r(1, 1'b0);
        exp_m(1, DS); exp_s(2, DM);
        ARVALID_M[0] = 1'b1; ARADDR_M[0] = 32'h0002_0000;       // pointer now at M2
        ARVALID_M[2] = 1'b1; ARADDR_M[2] = 32'h0002_0004;
        step();                                                 // c6
        exp_m(2, 2); exp_m(0, DS); exp_s(2, 2);
        ARREADY_M[2] = 1'b1; step();                            // c7
        ARVALID_M[2] = 1'b0; ARREADY_M[2] = 1'b0; set_r(2, 1'b1);
        step();                                                 // c8
        set_r(2, 1'b0);
        exp_m(2, DS); exp_s(2, DM); step();                     // c9
        exp_m(0, 2); exp_s(2, 0);
        ARREADY_M[0] = 1'b1; step();                            // c10 (wrapped to M0)
        ARVALID_M[0] = 1'b0; ARREADY_M[0] = 1'b0; set_r(0, 1'b1);
        step();                                                 // c11
        set_r(0, 1'b0);
        exp_m(0, DS); exp_s(2, DM); step();                     // c12

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the sequence above stalls for any reason.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
